// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the pc, drives the imem address, and buffers
// {pc, inst} pairs in a small FIFO toward decode. Redirects flush the buffer.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        misalign_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;

    logic [31:0]      pc_mem_q   [FIFO_DEPTH];
    logic [31:0]      inst_mem_q [FIFO_DEPTH];

    logic             full;
    logic             pop;
    logic             push;

    assign full      = (count_q == DEPTH_C);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full buffer still accepts a fetch when decode drains the head in the same cycle.
    assign push      = !redirect_valid & (!full | pop);

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;
    assign out_pc       = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign out_inst     = out_valid ? inst_mem_q[rd_ptr_q] : '0;

    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= imem_inst;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, streaming, backpressure, redirects,
// misalignment, pc wrap and asynchronous mid-cycle reset.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        misalign_err;

    int unsigned vectors;
    int unsigned miscompares;

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .misalign_err  (misalign_err)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'h0000_0000)      return 32'h0050_0093;
        else if (a == 32'h0000_0004) return 32'h00a0_0113;
        else                         return a ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_inst = inst_of(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state
        #12;
        check("rst_valid",    32'(out_valid),    32'd0);
        check("rst_pc",       out_pc,            32'h0);
        check("rst_inst",     out_inst,          32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_addr",     imem_addr,         32'h0);
        rst = 1'b0;

        // 1: streaming with out_ready high
        step();
        check("t1c1_valid", 32'(out_valid), 32'd1);
        check("t1c1_pc",    out_pc,         32'h0);
        check("t1c1_inst",  out_inst,       32'h0050_0093);
        check("t1c1_addr",  imem_addr,      32'h4);
        step();
        check("t1c2_pc",    out_pc,         32'h4);
        check("t1c2_inst",  out_inst,       32'h00a0_0113);
        check("t1c2_addr",  imem_addr,      32'h8);

        // 2: backpressure from reset
        rst       = 1'b1;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t2_addr_hold", imem_addr,      32'h8);
        check("t2_head_pc",   out_pc,         32'h0);
        check("t2_head_inst", out_inst,       32'h0050_0093);
        check("t2_valid",     32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("t2_d4_pc",   out_pc,    32'h4);
        check("t2_d4_addr", imem_addr, 32'hC);
        step();
        check("t2_d8_pc",   out_pc,    32'h8);
        check("t2_d8_inst", out_inst,  inst_of(32'h8));
        step();
        check("t2_d12_pc",  out_pc,    32'hC);
        check("t2_d12_addr", imem_addr, 32'h14);

        // 3: redirect while full and draining
        redirect_valid = 1'b1;
        redirect_pc    = 32'h24;
        step();
        redirect_valid = 1'b0;
        check("t3_valid0", 32'(out_valid), 32'd0);
        check("t3_pc0",    out_pc,         32'h0);
        check("t3_addr",   imem_addr,      32'h24);
        step();
        check("t3_valid1", 32'(out_valid), 32'd1);
        check("t3_tgt_pc", out_pc,         32'h24);
        check("t3_tgt_in", out_inst,       inst_of(32'h24));
        check("t3_addr2",  imem_addr,      32'h28);
        step();
        check("t3_next_pc", out_pc,        32'h28);

        // 4: misaligned redirect, sticky flag, back-to-back redirects
        redirect_valid = 1'b1;
        redirect_pc    = 32'h26;
        step();
        redirect_valid = 1'b0;
        check("t4_misalign", 32'(misalign_err), 32'd1);
        check("t4_addr",     imem_addr,         32'h24);
        check("t4_valid0",   32'(out_valid),    32'd0);
        step();
        check("t4_pc",       out_pc,            32'h24);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check("t4_sticky1",  32'(misalign_err), 32'd1);
        check("t4_addr100",  imem_addr,         32'h100);
        redirect_pc = 32'h200;
        step();
        check("t4_addr200",  imem_addr,         32'h200);
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("t4_addr300",  imem_addr,         32'h300);
        check("t4_b2b_val",  32'(out_valid),    32'd0);
        step();
        check("t4_b2b_pc",   out_pc,            32'h300);
        check("t4_sticky2",  32'(misalign_err), 32'd1);

        // 5: pc wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check("t5_pc_top",   out_pc,    32'hFFFF_FFFC);
        check("t5_addr_0",   imem_addr, 32'h0);
        step();
        check("t5_pc_0",     out_pc,    32'h0);
        check("t5_inst_0",   out_inst,  32'h0050_0093);
        step();
        check("t5_pc_4",     out_pc,    32'h4);
        check("t5_addr_8",   imem_addr, 32'h8);

        // 6: asynchronous reset mid-cycle with two entries buffered
        out_ready = 1'b0;
        step();
        check("t6_full_addr", imem_addr, 32'hC);
        check("t6_head",      out_pc,    32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid",    32'(out_valid),    32'd0);
        check("t6_pc",       out_pc,            32'h0);
        check("t6_inst",     out_inst,          32'h0);
        check("t6_addr",     imem_addr,         32'h0);
        check("t6_misalign", 32'(misalign_err), 32'd0);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check("t6_rs_valid", 32'(out_valid), 32'd1);
        check("t6_rs_pc",    out_pc,         32'h0);
        check("t6_rs_addr",  imem_addr,      32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
